// File: rtl/traffic_phase_sequencer.sv
// Parametrised main/side-road traffic phase sequencer with pedestrian service.
// Owns the phase FSM and tick counter and drives registered lamp and walk outputs.
module traffic_phase_sequencer #(
   parameter int unsigned CNT_W    = 6,
   parameter int unsigned MG_MIN_T = 15,
   parameter int unsigned Y_T      = 2,
   parameter int unsigned AR_T     = 2,
   parameter int unsigned SG_T     = 10,
   parameter int unsigned WALK_T   = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             ped_req,
   input  logic             side_sense,
   output logic [2:0]       main_light,
   output logic [2:0]       side_light,
   output logic             walk,
   output logic             walk_flash,
   output logic             ped_pending,
   output logic [CNT_W-1:0] phase_cnt,
   output logic             phase_done
);

   localparam longint unsigned CNT_RANGE = longint'(1) << CNT_W;

   if (WALK_T > SG_T || MG_MIN_T == 0 || Y_T == 0 || AR_T == 0 || SG_T == 0 ||
       WALK_T == 0 || longint'(MG_MIN_T) > CNT_RANGE || longint'(Y_T) > CNT_RANGE ||
       longint'(AR_T) > CNT_RANGE || longint'(SG_T) > CNT_RANGE) begin : g_param_err
      $error("traffic_phase_sequencer: illegal duration parameters");
   end

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] MG_TERM    = CNT_W'(MG_MIN_T - 1);
   localparam logic [CNT_W-1:0] Y_TERM     = CNT_W'(Y_T - 1);
   localparam logic [CNT_W-1:0] AR_TERM    = CNT_W'(AR_T - 1);
   localparam logic [CNT_W-1:0] SG_TERM    = CNT_W'(SG_T - 1);
   localparam logic [CNT_W:0]   WALK_LIM   = (CNT_W+1)'(WALK_T);
   localparam logic             WALK_PAR   = 1'(WALK_T % 2);
   localparam logic [2:0]       LAMP_RED   = 3'b100;
   localparam logic [2:0]       LAMP_YEL   = 3'b010;
   localparam logic [2:0]       LAMP_GRN   = 3'b001;

   typedef enum logic [2:0] {ST_MG, ST_MY, ST_AR1, ST_SG, ST_SY, ST_AR2} state_t;

   state_t           state, state_d;
   logic             served, served_d;
   logic             xfer;
   logic [CNT_W-1:0] cnt_d;
   logic             ped_d;
   logic             walk_d, flash_d;
   logic [2:0]       main_d, side_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_MG;
         served      <= 1'b0;
         phase_cnt   <= '0;
         ped_pending <= 1'b0;
         phase_done  <= 1'b0;
         walk        <= 1'b0;
         walk_flash  <= 1'b0;
         main_light  <= LAMP_GRN;
         side_light  <= LAMP_RED;
      end else begin
         state       <= state_d;
         served      <= served_d;
         phase_cnt   <= cnt_d;
         ped_pending <= ped_d;
         phase_done  <= xfer;
         walk        <= walk_d;
         walk_flash  <= flash_d;
         main_light  <= main_d;
         side_light  <= side_d;
      end
   end

   always_comb begin
      state_d  = state;
      served_d = served;
      cnt_d    = phase_cnt;
      ped_d    = ped_pending;
      walk_d   = 1'b0;
      flash_d  = 1'b0;
      main_d   = LAMP_RED;
      side_d   = LAMP_RED;

      if (tick) begin
         unique case (state)
            ST_MG:  if (phase_cnt >= MG_TERM && (ped_pending || ped_req || side_sense))
                       state_d = ST_MY;
            ST_MY:  if (phase_cnt == Y_TERM)  state_d = ST_AR1;
            ST_AR1: if (phase_cnt == AR_TERM) state_d = ST_SG;
            ST_SG:  if (phase_cnt == SG_TERM) state_d = ST_SY;
            ST_SY:  if (phase_cnt == Y_TERM)  state_d = ST_AR2;
            ST_AR2: if (phase_cnt == AR_TERM) state_d = ST_MG;
            default: state_d = ST_MG;
         endcase
      end
      xfer = (state_d != state);

      // Counter saturates so an idle main green never wraps back below its minimum.
      if (xfer)
         cnt_d = '0;
      else if (tick && phase_cnt != CNT_MAX)
         cnt_d = phase_cnt + CNT_W'(1);

      // Entering side green serves the request; a press in that same cycle is absorbed.
      if (xfer && state == ST_AR1) begin
         ped_d    = 1'b0;
         served_d = ped_pending | ped_req;
      end else begin
         if (ped_req) ped_d = 1'b1;
         if (xfer && state == ST_SG) served_d = 1'b0;
      end

      if (state_d == ST_SG && served_d) begin
         if ({1'b0, cnt_d} < WALK_LIM) walk_d  = 1'b1;
         else                          flash_d = ~(cnt_d[0] ^ WALK_PAR);
      end

      unique case (state_d)
         ST_MG:   main_d = LAMP_GRN;
         ST_MY:   main_d = LAMP_YEL;
         ST_SG:   side_d = LAMP_GRN;
         ST_SY:   side_d = LAMP_YEL;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed self-checking bench for traffic_phase_sequencer at default parameters.
module tb_traffic_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic       ped_req;
   logic       side_sense;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic       walk;
   logic       walk_flash;
   logic       ped_pending;
   logic [5:0] phase_cnt;
   logic       phase_done;

   int n_assert = 0;
   int n_fail   = 0;

   traffic_phase_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .ped_req    (ped_req),
      .side_sense (side_sense),
      .main_light (main_light),
      .side_light (side_light),
      .walk       (walk),
      .walk_flash (walk_flash),
      .ped_pending(ped_pending),
      .phase_cnt  (phase_cnt),
      .phase_done (phase_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clk1(input logic t);
      tick = t;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) clk1(1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_main"}, 32'(main_light), 32'h1);
      chk({tag, "_side"}, 32'(side_light), 32'h4);
      chk({tag, "_cnt"},  32'(phase_cnt), 32'd0);
      chk({tag, "_done"}, 32'(phase_done), 32'd0);
      chk({tag, "_walk"}, 32'(walk), 32'd0);
      chk({tag, "_flash"}, 32'(walk_flash), 32'd0);
      chk({tag, "_ped"},  32'(ped_pending), 32'd0);
   endtask

   initial begin
      int  dones;
      logic exp_flash;
      rst_n = 1'b0; tick = 1'b0; ped_req = 1'b0; side_sense = 1'b0;
      #12;
      chk_reset_vals("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Idle: main green holds, counter saturates, no phase pulses
      for (int i = 1; i <= 70; i++) begin
         clk1(1'b1);
         chk("idle_done", 32'(phase_done), 32'd0);
         if (i == 30) chk("idle_cnt30", 32'(phase_cnt), 32'd30);
      end
      chk("idle_sat", 32'(phase_cnt), 32'd63);
      chk("idle_main", 32'(main_light), 32'h1);
      chk("idle_side", 32'(side_light), 32'h4);

      // Side vehicle only: full cycle, no walk, six phase pulses
      do_reset();
      side_sense = 1'b1;
      dones = 0;
      for (int i = 1; i <= 33; i++) begin
         clk1(1'b1);
         if (phase_done) dones++;
         chk("veh_walk", 32'(walk), 32'd0);
         if (i == 14) chk("veh_mg14", 32'(main_light), 32'h1);
         if (i == 15) begin
            chk("veh_my", 32'(main_light), 32'h2);
            chk("veh_my_cnt", 32'(phase_cnt), 32'd0);
            side_sense = 1'b0;
         end
         if (i == 17) chk("veh_ar1", 32'({main_light, side_light}), 32'h24);
         if (i == 19) chk("veh_sg", 32'({main_light, side_light}), 32'h21);
         if (i == 28) chk("veh_sg_end", 32'(side_light), 32'h1);
         if (i == 29) chk("veh_sy", 32'({main_light, side_light}), 32'h22);
         if (i == 31) chk("veh_ar2", 32'({main_light, side_light}), 32'h24);
      end
      chk("veh_back_mg", 32'({main_light, side_light}), 32'h0c);
      chk("veh_dones", 32'(dones), 32'd6);

      // Pedestrian pulse at MG count 3
      do_reset();
      ticks(3);
      chk("ped_cnt3", 32'(phase_cnt), 32'd3);
      ped_req = 1'b1;
      clk1(1'b1);
      ped_req = 1'b0;
      chk("ped_latched", 32'(ped_pending), 32'd1);
      ticks(11);
      chk("ped_my", 32'(main_light), 32'h2);
      chk("ped_my_pend", 32'(ped_pending), 32'd1);
      ticks(3);
      chk("ped_ar1_pend", 32'(ped_pending), 32'd1);
      clk1(1'b1);
      for (int k = 0; k < 10; k++) begin
         exp_flash = (k >= 6) ? ((k - 6) % 2 == 0) : 1'b0;
         chk("ped_sg_side", 32'(side_light), 32'h1);
         chk("ped_sg_walk", 32'(walk), (k < 6) ? 32'd1 : 32'd0);
         chk("ped_sg_flash", 32'(walk_flash), 32'(exp_flash));
         chk("ped_sg_pend", 32'(ped_pending), 32'd0);
         clk1(1'b1);
      end
      chk("ped_sy_side", 32'(side_light), 32'h2);
      chk("ped_sy_walk", 32'({walk, walk_flash}), 32'd0);

      // Press on the AR1->SG edge is absorbed; press in SY is kept
      do_reset();
      side_sense = 1'b1;
      ticks(15);
      side_sense = 1'b0;
      ticks(3);
      chk("abs_ar1", 32'({main_light, side_light}), 32'h24);
      ped_req = 1'b1;
      clk1(1'b1);
      ped_req = 1'b0;
      chk("abs_sg", 32'(side_light), 32'h1);
      chk("abs_pend0", 32'(ped_pending), 32'd0);
      clk1(1'b1);
      chk("abs_pend1", 32'(ped_pending), 32'd0);
      ticks(9);
      chk("sy_side", 32'(side_light), 32'h2);
      ped_req = 1'b1;
      clk1(1'b1);
      ped_req = 1'b0;
      chk("sy_pend", 32'(ped_pending), 32'd1);
      ticks(3);
      chk("sy_back_mg", 32'(main_light), 32'h1);
      chk("sy_mg_pend", 32'(ped_pending), 32'd1);
      ticks(14);
      chk("sy_mg_hold", 32'(main_light), 32'h1);
      clk1(1'b1);
      chk("sy_mg_exit", 32'(main_light), 32'h2);

      // Tick stall in the middle of yellow
      clk1(1'b1);
      chk("stall_cnt1", 32'(phase_cnt), 32'd1);
      for (int i = 0; i < 50; i++) clk1(1'b0);
      chk("stall_main", 32'(main_light), 32'h2);
      chk("stall_cnt", 32'(phase_cnt), 32'd1);
      chk("stall_done", 32'(phase_done), 32'd0);
      clk1(1'b1);
      chk("stall_ar1", 32'({main_light, side_light}), 32'h24);
      chk("stall_ar1_done", 32'(phase_done), 32'd1);
      chk("stall_ar1_cnt", 32'(phase_cnt), 32'd0);

      // Asynchronous reset during served side green
      ticks(2);
      chk("ar_sg_walk", 32'(walk), 32'd1);
      ped_req = 1'b1;
      clk1(1'b1);
      ped_req = 1'b0;
      chk("ar_sg_walk2", 32'(walk), 32'd1);
      chk("ar_sg_pend", 32'(ped_pending), 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      @(posedge clk); #1;
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
